// File: rtl/lcd_bus_receiver.sv
// Receiver for an HD44780-style 4-bit LCD bus: rebuilds bytes, tracks the cursor, flags character writes.
// Latency: outputs update on the 3rd clk edge after lcd_e is first sampled low.
// Backpressure: none. The bus is only observed, and every accepted strobe is reported.
//
// Ports: clk/reset (sync, active-high); lcd_rs/lcd_e/lcd_data (asynchronous bus inputs);
//        rx_data/rx_rs/rx_valid (assembled byte); mode4 (1 = 4-bit mode); cursor_addr (DDRAM address);
//        char_wr/char_data/char_addr (character write event); clear_evt; nibble_err (low-nibble timeout).
module lcd_bus_receiver #(
    parameter int E_MIN_HIGH = 2,
    parameter int TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lcd_rs,
    input  logic       lcd_e,
    input  logic [3:0] lcd_data,
    output logic [7:0] rx_data,
    output logic       rx_rs,
    output logic       rx_valid,
    output logic       mode4,
    output logic [6:0] cursor_addr,
    output logic       char_wr,
    output logic [7:0] char_data,
    output logic [6:0] char_addr,
    output logic       clear_evt,
    output logic       nibble_err
);

    localparam int HW = (E_MIN_HIGH < 1) ? 1 : $clog2(E_MIN_HIGH + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [HW-1:0] HMAX  = HW'(E_MIN_HIGH);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_HI,
        ST_LO
    } state_t;

    state_t          state;
    logic            rs_s1, rs_s2;
    logic            e_s1, e_s2, e_d;
    logic [3:0]      d_s1, d_s2;
    logic [HW-1:0]   hcnt;
    logic [TW-1:0]   tcnt;
    logic [3:0]      hi_nib;
    logic            hi_rs;

    logic            strobe;
    logic            byte_done;
    logic [7:0]      asm_byte;
    logic            asm_rs;
    logic [6:0]      cursor_inc;

    always_comb begin
        // The high-count still holds the length of the pulse during the fall cycle,
        // because it is only cleared on the edge that ends that cycle.
        strobe    = e_d & ~e_s2 & (hcnt >= HMAX);
        byte_done = strobe & (state != ST_HI);
        if (state == ST_LO) begin
            asm_byte = {hi_nib, d_s2};
            asm_rs   = hi_rs;
        end else begin
            asm_byte = {d_s2, 4'h0};
            asm_rs   = rs_s2;
        end
        // The two display lines are 0x00-0x0F and 0x40-0x4F, so the cursor jumps between them.
        if (cursor_addr == 7'h0F) begin
            cursor_inc = 7'h40;
        end else if (cursor_addr == 7'h4F) begin
            cursor_inc = 7'h00;
        end else begin
            cursor_inc = cursor_addr + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_INIT;
            rs_s1       <= 1'b0;
            rs_s2       <= 1'b0;
            e_s1        <= 1'b0;
            e_s2        <= 1'b0;
            e_d         <= 1'b0;
            d_s1        <= 4'h0;
            d_s2        <= 4'h0;
            hcnt        <= '0;
            tcnt        <= '0;
            hi_nib      <= 4'h0;
            hi_rs       <= 1'b0;
            rx_data     <= 8'h00;
            rx_rs       <= 1'b0;
            rx_valid    <= 1'b0;
            mode4       <= 1'b0;
            cursor_addr <= 7'h00;
            char_wr     <= 1'b0;
            char_data   <= 8'h00;
            char_addr   <= 7'h00;
            clear_evt   <= 1'b0;
            nibble_err  <= 1'b0;
        end else begin
            rs_s1 <= lcd_rs;
            rs_s2 <= rs_s1;
            e_s1  <= lcd_e;
            e_s2  <= e_s1;
            e_d   <= e_s2;
            d_s1  <= lcd_data;
            d_s2  <= d_s1;

            if (!e_s2) begin
                hcnt <= '0;
            end else if (hcnt < HMAX) begin
                hcnt <= hcnt + 1'b1;
            end

            rx_valid   <= 1'b0;
            char_wr    <= 1'b0;
            clear_evt  <= 1'b0;
            nibble_err <= 1'b0;

            case (state)
                ST_INIT: begin
                    if (strobe && !rs_s2 && d_s2 == 4'h2) begin
                        state <= ST_HI;
                        mode4 <= 1'b1;
                    end
                end
                ST_HI: begin
                    if (strobe) begin
                        hi_nib <= d_s2;
                        hi_rs  <= rs_s2;
                        tcnt   <= '0;
                        state  <= ST_LO;
                    end
                end
                ST_LO: begin
                    // A strobe landing in the timeout cycle still completes the byte.
                    if (strobe) begin
                        state <= ST_HI;
                    end else if (tcnt == TLAST) begin
                        nibble_err <= 1'b1;
                        state      <= ST_HI;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase

            if (byte_done) begin
                rx_data  <= asm_byte;
                rx_rs    <= asm_rs;
                rx_valid <= 1'b1;
                if (asm_rs) begin
                    char_wr     <= 1'b1;
                    char_data   <= asm_byte;
                    char_addr   <= cursor_addr;
                    cursor_addr <= cursor_inc;
                end else if (asm_byte == 8'h01) begin
                    cursor_addr <= 7'h00;
                    clear_evt   <= 1'b1;
                end else if (asm_byte == 8'h02 || asm_byte == 8'h03) begin
                    cursor_addr <= 7'h00;
                end else if (asm_byte[7]) begin
                    cursor_addr <= asm_byte[6:0];
                end else if (asm_byte[7:4] == 4'h3 && state != ST_INIT) begin
                    // Function set with DL=1: the host is re-running the init sequence.
                    // Placed after the case so it overrides the LO->HI transition.
                    state <= ST_INIT;
                    mode4 <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
module tb_lcd_bus_receiver;

    localparam int E_MIN_HIGH = 2;
    localparam int TIMEOUT    = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       lcd_rs;
    logic       lcd_e;
    logic [3:0] lcd_data;
    logic [7:0] rx_data;
    logic       rx_rs;
    logic       rx_valid;
    logic       mode4;
    logic [6:0] cursor_addr;
    logic       char_wr;
    logic [7:0] char_data;
    logic [6:0] char_addr;
    logic       clear_evt;
    logic       nibble_err;

    lcd_bus_receiver #(
        .E_MIN_HIGH(E_MIN_HIGH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lcd_rs     (lcd_rs),
        .lcd_e      (lcd_e),
        .lcd_data   (lcd_data),
        .rx_data    (rx_data),
        .rx_rs      (rx_rs),
        .rx_valid   (rx_valid),
        .mode4      (mode4),
        .cursor_addr(cursor_addr),
        .char_wr    (char_wr),
        .char_data  (char_data),
        .char_addr  (char_addr),
        .clear_evt  (clear_evt),
        .nibble_err (nibble_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observed events, sampled on the falling edge.
    logic [8:0]  ob_rx[$];
    logic [14:0] ob_ch[$];
    int          ob_clr = 0;
    int          ob_err = 0;

    always @(negedge clk) begin
        if (rx_valid)   ob_rx.push_back({rx_rs, rx_data});
        if (char_wr)    ob_ch.push_back({char_addr, char_data});
        if (clear_evt)  ob_clr++;
        if (nibble_err) ob_err++;
    end

    // Reference model: works on whole strobes and bytes, not on cycles.
    bit          m_mode4;
    int          m_cursor;
    bit          m_pend;
    logic [3:0]  m_hi;
    logic        m_hrs;
    logic [8:0]  ex_rx[$];
    logic [14:0] ex_ch[$];
    int          ex_clr = 0;
    int          ex_err = 0;

    function automatic void model_reset();
        m_mode4  = 0;
        m_cursor = 0;
        m_pend   = 0;
        m_hi     = 4'h0;
        m_hrs    = 1'b0;
    endfunction

    function automatic void model_byte(input logic r, input logic [7:0] b);
        logic [6:0] a;
        ex_rx.push_back({r, b});
        if (r) begin
            a = 7'(m_cursor);
            ex_ch.push_back({a, b});
            if (m_cursor == 15)      m_cursor = 64;
            else if (m_cursor == 79) m_cursor = 0;
            else                     m_cursor = (m_cursor + 1) % 128;
        end else if (b == 8'h01) begin
            m_cursor = 0;
            ex_clr++;
        end else if (b == 8'h02 || b == 8'h03) begin
            m_cursor = 0;
        end else if (b >= 8'h80) begin
            m_cursor = int'(b) - 128;
        end else if (b >= 8'h30 && b <= 8'h3F) begin
            m_mode4 = 0;
            m_pend  = 0;
        end
    endfunction

    function automatic void model_strobe(input logic r, input logic [3:0] n);
        if (!m_mode4) begin
            model_byte(r, {n, 4'h0});
            if (!r && n == 4'h2) m_mode4 = 1;
        end else if (!m_pend) begin
            m_pend = 1;
            m_hi   = n;
            m_hrs  = r;
        end else begin
            m_pend = 0;
            model_byte(m_hrs, {m_hi, n});
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        chk({tag, ".rx_count"}, ob_rx.size(), ex_rx.size());
        n = (ob_rx.size() < ex_rx.size()) ? ob_rx.size() : ex_rx.size();
        for (int i = 0; i < n; i++) chk({tag, ".rx_byte"}, 32'(ob_rx[i]), 32'(ex_rx[i]));
        chk({tag, ".char_count"}, ob_ch.size(), ex_ch.size());
        n = (ob_ch.size() < ex_ch.size()) ? ob_ch.size() : ex_ch.size();
        for (int i = 0; i < n; i++) chk({tag, ".char_addr_data"}, 32'(ob_ch[i]), 32'(ex_ch[i]));
        chk({tag, ".clear_evt"}, ob_clr, ex_clr);
        chk({tag, ".nibble_err"}, ob_err, ex_err);
        chk({tag, ".cursor_addr"}, 32'(cursor_addr), 32'(m_cursor));
        chk({tag, ".mode4"}, 32'(mode4), 32'(m_mode4));
        ob_rx.delete();
        ob_ch.delete();
        ex_rx.delete();
        ex_ch.delete();
        ob_clr = 0;
        ob_err = 0;
        ex_clr = 0;
        ex_err = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".rx_data"}, 32'(rx_data), 0);
        chk({tag, ".rx_rs"}, 32'(rx_rs), 0);
        chk({tag, ".rx_valid"}, 32'(rx_valid), 0);
        chk({tag, ".mode4"}, 32'(mode4), 0);
        chk({tag, ".cursor_addr"}, 32'(cursor_addr), 0);
        chk({tag, ".char_wr"}, 32'(char_wr), 0);
        chk({tag, ".char_data"}, 32'(char_data), 0);
        chk({tag, ".char_addr"}, 32'(char_addr), 0);
        chk({tag, ".clear_evt"}, 32'(clear_evt), 0);
        chk({tag, ".nibble_err"}, 32'(nibble_err), 0);
    endtask

    // One E pulse of w cycles; called on a falling clock edge and returns on one.
    task automatic strobe(input logic r, input logic [3:0] n, input int w, input bit lat);
        lcd_rs   = r;
        lcd_data = n;
        lcd_e    = 1'b1;
        repeat (w) @(negedge clk);
        lcd_e = 1'b0;
        if (lat) begin
            @(negedge clk);
            @(negedge clk);
            chk("latency.before_3rd_edge", 32'(rx_valid), 0);
            @(negedge clk);
            chk("latency.after_3rd_edge", 32'(rx_valid), 1);
            @(negedge clk);
            chk("latency.one_cycle", 32'(rx_valid), 0);
            repeat (3) @(negedge clk);
        end else begin
            repeat (6) @(negedge clk);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] n, input int w);
        strobe(r, n, w, 1'b0);
        model_strobe(r, n);
    endtask

    task automatic send_byte(input logic r, input logic [7:0] b);
        step(r, b[7:4], $urandom_range(2, 4));
        step(r, b[3:0], $urandom_range(2, 4));
    endtask

    initial begin
        logic [7:0] b;
        logic       r;
        int         k;

        reset    = 1'b1;
        lcd_rs   = 1'b0;
        lcd_e    = 1'b0;
        lcd_data = 4'h0;
        model_reset();
        repeat (4) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // Init sequence, with exact latency on the first strobe.
        strobe(1'b0, 4'h3, 5, 1'b1);
        model_strobe(1'b0, 4'h3);
        step(1'b0, 4'h3, 5);
        step(1'b0, 4'h3, 5);
        step(1'b0, 4'h2, 5);
        check_all("init");

        send_byte(1'b1, 8'h41);
        check_all("write_41");

        send_byte(1'b0, 8'h8F);
        send_byte(1'b1, 8'h41);
        check_all("wrap_line1");
        send_byte(1'b0, 8'hCF);
        send_byte(1'b1, 8'h42);
        check_all("wrap_line2");
        send_byte(1'b0, 8'h01);
        check_all("clear");

        // High nibble only: the partial byte must be dropped after TIMEOUT cycles.
        strobe(1'b1, 4'h4, 3, 1'b0);
        repeat (TIMEOUT + 8) @(negedge clk);
        ex_err++;
        m_pend = 0;
        check_all("timeout");
        send_byte(1'b1, 8'h5A);
        check_all("after_timeout");

        // One-cycle E pulse is shorter than E_MIN_HIGH and must leave no trace.
        strobe(1'b1, 4'h7, 1, 1'b0);
        check_all("glitch");
        send_byte(1'b1, 8'h62);
        check_all("after_glitch");

        for (int it = 0; it < 40; it++) begin
            r = 1'($urandom_range(0, 1));
            if (r) begin
                b = 8'($urandom_range(32, 126));
            end else begin
                k = $urandom_range(0, 5);
                case (k)
                    0:       b = 8'h01;
                    1:       b = 8'($urandom_range(2, 3));
                    2:       b = 8'($urandom_range(128, 255));
                    3:       b = 8'($urandom_range(4, 31));
                    4:       b = 8'h28;
                    default: b = 8'($urandom_range(48, 63));
                endcase
            end
            send_byte(r, b);
            if (!m_mode4) step(1'b0, 4'h2, 3);
            if ($urandom_range(0, 3) == 0) strobe(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1, 1'b0);
            check_all("random");
        end

        // Reset with a half-received byte pending.
        strobe(1'b1, 4'h6, 3, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_zero("reset_mid");
        model_reset();
        ob_rx.delete();
        ob_ch.delete();
        ob_clr = 0;
        ob_err = 0;
        step(1'b0, 4'h3, 3);
        check_all("after_reset_mid");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lcd_bus_receiver.md
Name: lcd_bus_receiver

Overview:
- Receiving end of the HD44780-style 4-bit LCD bus (lcd_rs, lcd_e, lcd_data) that our LCD driver produces.
- Samples the bus in the system clock domain and reassembles nibbles into bytes, including the 8-bit-mode init phase.
- Decodes cursor-affecting commands and emits character-write events with the DDRAM address each character lands at.
- Used as an on-chip bus monitor for the mini CPU display path and as a self-checking element in system benches.

Parameters:
- E_MIN_HIGH, 2: minimum consecutive synchronized-high cycles of lcd_e for a falling edge to be accepted as a strobe.
- TIMEOUT, 100000: cycles allowed between the high and low nibble of one byte before the partial byte is discarded.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- lcd_rs  input  1  bus register select (0 = command, 1 = data).
- lcd_e  input  1  bus enable strobe; data is latched on its falling edge.
- lcd_data  input  4  bus data nibble.
- rx_data  output  8  last assembled byte.
- rx_rs  output  1  rs value of the byte in rx_data.
- rx_valid  output  1  one-cycle pulse when rx_data/rx_rs update.
- mode4  output  1  1 = 4-bit mode, 0 = 8-bit init mode.
- cursor_addr  output  7  current DDRAM address.
- char_wr  output  1  one-cycle pulse on a data byte (rs=1).
- char_data  output  8  character written.
- char_addr  output  7  address the character was written to (pre-increment).
- clear_evt  output  1  one-cycle pulse on a clear-display command.
- nibble_err  output  1  one-cycle pulse on a low-nibble timeout.

Behaviour:
- Reset values: every output 0; mode4=0; cursor_addr=0; synchronizers, counters and the half-byte flag cleared. Reset mid-byte discards the partial byte.
- Input sync: lcd_rs, lcd_e and lcd_data each pass through a 2-flop synchronizer; e_d is the stage-2 value of lcd_e delayed one cycle.
- Strobe: fall = e_d & ~e_s2, gated by a high-count.
  - The high-count increments while e_s2=1 and saturates; it clears when e_s2=0.
  - The strobe is valid only if the high-count is >= E_MIN_HIGH.
  - rs and data are taken from the synchronized stage in the fall cycle.
- Latency: outputs register on the edge following the fall cycle. rx_valid (and char_wr/clear_evt) is high in the cycle after the 3rd clock edge counted from the edge that first samples lcd_e low.
- INIT state (mode4=0): each strobe is a complete byte = {nibble, 4'h0} and raises rx_valid.
  - rs=0 and nibble=4'h2 additionally moves the block to 4-bit mode (mode4=1).
- 4-bit mode, HI state: a strobe stores the high nibble and rs, moves to LO and starts the timeout counter.
- 4-bit mode, LO state: a strobe forms {hi, lo}, raises rx_valid and returns to HI.
  - rs is the value latched with the high nibble.
  - If the timeout counter reaches TIMEOUT before the low-nibble strobe, nibble_err pulses, the partial byte is dropped and the block returns to HI.
  - A strobe and the timeout in the same cycle: the strobe wins.
- Command decode (rs=0, applied in the same cycle as rx_valid):
  - 0x01: cursor_addr=0, clear_evt pulses.
  - 0x02 or 0x03: cursor_addr=0.
  - 0x80–0xFF: cursor_addr=byte[6:0].
  - 0x20–0x3F with bit4=1 (DL=8-bit) in 4-bit mode: mode4=0 (back to INIT).
  - All other commands: rx_valid only.
  - INIT-mode bytes are also decoded (e.g. 0x30 has no effect).
- Data (rs=1):
  - char_wr pulses, char_data=byte, char_addr=cursor_addr before increment.
  - Cursor then advances: 0x0F→0x40; 0x4F→0x00; any other value +1 modulo 128 (0x7F→0x00).
- Edges while reset=1 are ignored. A strobe whose high time is shorter than E_MIN_HIGH is ignored completely: no state change, no timeout reset.

Test Plan:
- Init sequence: reset, then rs=0 nibbles 3,3,3,2 each with E high 5 cycles → four rx_valid pulses with rx_data 0x30,0x30,0x30,0x20; mode4=1 after the 4th; rx_valid timed 3 edges after E is sampled low.
- 4-bit write: in mode4, rs=1 nibbles 4,1 → rx_data=0x41, char_wr with char_data=0x41, char_addr=0x00; cursor_addr becomes 0x01.
- Cursor wrap: command 0x8F, then data 'A' → char_addr 0x0F, cursor 0x40. Command 0xCF, then data 'B' → char_addr 0x4F, cursor 0x00. Command 0x01 → clear_evt, cursor 0.
- Timeout: send high nibble 0x4 only, wait TIMEOUT=16 (bench override) cycles → nibble_err pulses once, no rx_valid; the next pair 5,A yields 0x5A.
- Glitch reject: E high 1 cycle with E_MIN_HIGH=2 → no rx_valid, state unchanged; a following valid pair decodes correctly.
- Reset mid-byte: high nibble sent, reset asserted 1 cycle → all outputs 0, mode4=0; the next single strobe with nibble 0x3 gives rx_data 0x30.
